// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the bubble control field set used by the
// inter-stage registers of the 5-stage MIPS core.
package pipe_pkg;

  localparam int unsigned TNEW_W = 4;

  // Result source of the instruction occupying a stage
  localparam logic [1:0] FWD_ALU = 2'd0;
  localparam logic [1:0] FWD_PC8 = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Control fields that a bubble forces; the PCs keep flowing for traceability
  typedef struct packed {
    logic [31:0]       instr;
    logic              regwrite;
    logic              memwrite;
    logic [4:0]        writereg;
    logic [TNEW_W-1:0] tnew;
    logic [1:0]        fwd_sel;
  } bubble_t;

  localparam bubble_t BUBBLE = '{
    instr:    NOP_INSTR,
    regwrite: 1'b0,
    memwrite: 1'b0,
    writereg: 5'd0,
    tnew:     '0,
    fwd_sel:  FWD_ALU
  };

endpackage

// File: rtl/tnew_dec.sv
// Saturating Tnew decrementer shared by the E->M and M->W pipeline registers.
module tnew_dec #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] tnew_cur,
  output logic [W-1:0] tnew_next
);

  always_comb begin
    tnew_next = tnew_cur;
    if (tnew_cur == '0) begin
      tnew_next = '0;
    end else begin
      tnew_next = tnew_cur - W'(1);
    end
  end

endmodule

// File: rtl/e_to_m_pipe_reg.sv
// Execute -> Memory pipeline register with stall, deferred flush and M-stage forwarding source.
// Optional bubble counter output enabled by defining EM_BUBBLE_CNT_EN.
module e_to_m_pipe_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned TNEW_W = pipe_pkg::TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_m,
  input  logic              flush_m,
  input  logic [WIDTH-1:0]  instr_e,
  input  logic [WIDTH-1:0]  pc_e,
  input  logic [WIDTH-1:0]  pc8_e,
  input  logic [WIDTH-1:0]  alu_e,
  input  logic [WIDTH-1:0]  rt_data_e,
  input  logic [4:0]        writereg_e,
  input  logic [TNEW_W-1:0] tnew_e,
  input  logic [1:0]        fwd_sel_e,
  input  logic              regwrite_e,
  input  logic              memwrite_e,
  output logic [WIDTH-1:0]  instr_m,
  output logic [WIDTH-1:0]  pc_m,
  output logic [WIDTH-1:0]  pc8_m,
  output logic [WIDTH-1:0]  alu_m,
  output logic [WIDTH-1:0]  rt_data_m,
  output logic [4:0]        writereg_m,
  output logic [TNEW_W-1:0] tnew_m,
  output logic [1:0]        fwd_sel_m,
  output logic              regwrite_m,
  output logic              memwrite_m,
  output logic [WIDTH-1:0]  fwd_data_m,
  output logic              fwd_ready_m,
`ifdef EM_BUBBLE_CNT_EN
  output logic [31:0]       bubble_cnt,
`endif
  output logic              flush_pending
);

  import pipe_pkg::*;

  logic [TNEW_W-1:0] tnew_next;
  logic              load;
  logic              load_bubble;

  tnew_dec #(
    .W (TNEW_W)
  ) u_tnew_dec (
    .tnew_cur  (tnew_e),
    .tnew_next (tnew_next)
  );

  assign load        = !stall_m;
  // A flush seen while stalled is remembered and honoured on the first free edge
  assign load_bubble = load && (flush_m || flush_pending);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_m       <= '0;
      pc_m          <= '0;
      pc8_m         <= '0;
      alu_m         <= '0;
      rt_data_m     <= '0;
      writereg_m    <= '0;
      tnew_m        <= '0;
      fwd_sel_m     <= '0;
      regwrite_m    <= 1'b0;
      memwrite_m    <= 1'b0;
      flush_pending <= 1'b0;
    end else if (!load) begin
      if (flush_m) begin
        flush_pending <= 1'b1;
      end
    end else begin
      pc_m          <= pc_e;
      pc8_m         <= pc8_e;
      alu_m         <= alu_e;
      rt_data_m     <= rt_data_e;
      flush_pending <= 1'b0;
      if (load_bubble) begin
        instr_m    <= WIDTH'(BUBBLE.instr);
        regwrite_m <= BUBBLE.regwrite;
        memwrite_m <= BUBBLE.memwrite;
        writereg_m <= BUBBLE.writereg;
        tnew_m     <= '0;
        fwd_sel_m  <= BUBBLE.fwd_sel;
      end else begin
        instr_m    <= instr_e;
        regwrite_m <= regwrite_e;
        memwrite_m <= memwrite_e;
        writereg_m <= writereg_e;
        tnew_m     <= tnew_next;
        fwd_sel_m  <= fwd_sel_e;
      end
    end
  end

`ifdef EM_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (load_bubble) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    fwd_data_m = alu_m;
    if (fwd_sel_m == FWD_PC8) begin
      fwd_data_m = pc8_m;
    end
  end

  // Memory results (FWD_MEM and the reserved code) only forward from W
  assign fwd_ready_m = regwrite_m && (writereg_m != 5'd0) && (tnew_m == '0) &&
                       (fwd_sel_m != FWD_MEM) && (fwd_sel_m != 2'd3);

endmodule
